// File: rtl/ps2_serial_rx.sv
// ps2_serial_rx: PS/2 keyboard receiver. Synchronises the device-driven
// ps2_clk/ps2_data pair, assembles 11-bit frames (start, 8 data LSB-first,
// odd parity, stop), and presents good bytes with a ready flag held until
// the consumer acknowledges.
//
// Ports:
//   clk       system clock
//   clr       synchronous active-high reset
//   ps2_clk   PS/2 clock from device (asynchronous, idle high)
//   ps2_data  PS/2 data from device (asynchronous, idle high)
//   ack       consumer has taken data; clears rdy
//   data      last good received byte
//   rdy       data valid, held until ack
//   overrun   sticky: good frame arrived while rdy=1
//   err       one-cycle pulse on parity, stop or timeout failure
//
// Optional feature macro: PS2_CLK_FILTER_EN
//   defined   -> FILTER_LEN-sample stability filter on synced ps2_clk, with
//                ps2_data delayed by FILTER_LEN to keep sampling aligned
//   undefined -> synced ps2_clk used directly, FILTER_LEN unused
module ps2_serial_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ack,
  output logic [7:0] data,
  output logic       rdy,
  output logic       overrun,
  output logic       err
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Illegal parameter values leave this marker scope in the hierarchy.
  if (FILTER_LEN == 0 || TIMEOUT_CYCLES < 2) begin : g_unsupported_params
  end

  // Two-flop synchronisers; bit [1] is the synchronised value.
  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  logic w_clk;
  logic w_data;

`ifdef PS2_CLK_FILTER_EN
  localparam int unsigned FC_W = $clog2(FILTER_LEN + 1);

  logic                  r_clk_filt;
  logic [FC_W-1:0]       r_filt_cnt;
  logic [FILTER_LEN-1:0] r_data_dly;

  // Filtered clock flips only after FILTER_LEN consecutive differing samples;
  // data goes through a matching delay line.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
      r_data_dly <= '1;
    end else begin
      r_data_dly <= (r_data_dly << 1) | FILTER_LEN'(r_data_sync[1]);
      if (r_clk_sync[1] == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FC_W'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_clk  = r_clk_filt;
  assign w_data = r_data_dly[FILTER_LEN-1];
`else
  assign w_clk  = r_clk_sync[1];
  assign w_data = r_data_sync[1];
`endif

  state_t          r_state;
  logic            r_clk_prev;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_sr;
  logic            r_parity;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_data;
  logic            r_rdy;
  logic            r_overrun;
  logic            r_err;

  logic w_fall;
  logic w_timeout;
  logic w_good;

  assign w_fall    = r_clk_prev & ~w_clk;
  assign w_timeout = (r_to_cnt == TO_LAST);
  // Odd parity over data plus parity bit, and stop must be high.
  assign w_good    = w_data & (^r_sr ^ r_parity);

  // Frame FSM, timeout counter and consumer handshake.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_clk_prev <= 1'b1;
      r_bit_cnt  <= '0;
      r_sr       <= '0;
      r_parity   <= 1'b0;
      r_to_cnt   <= '0;
      r_data     <= '0;
      r_rdy      <= 1'b0;
      r_overrun  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_clk_prev <= w_clk;
      r_err      <= 1'b0;

      if (ack && r_rdy) begin
        r_rdy     <= 1'b0;
        r_overrun <= 1'b0;
      end

      // Saturating inactivity counter; held at zero while idle.
      if (w_fall || r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (!w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall && !w_data) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_sr      <= {w_data, r_sr[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_parity <= w_data;
            r_state  <= S_STOP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_state <= S_IDLE;
            if (w_good) begin
              // Same-cycle ack frees the holding register for the new byte.
              if (!r_rdy || ack) begin
                r_data <= r_sr;
                r_rdy  <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data    = r_data;
  assign rdy     = r_rdy;
  assign overrun = r_overrun;
  assign err     = r_err;

endmodule

// File: tb/tb_ps2_serial_rx.sv
// Directed testbench for ps2_serial_rx: drives PS/2 frames bit by bit and
// checks data/rdy/overrun/err against hand-computed expectations.
module tb_ps2_serial_rx;

  localparam int unsigned HALF = 20;
`ifdef PS2_CLK_FILTER_EN
  localparam int unsigned ACK_DLY = 10;
`else
  localparam int unsigned ACK_DLY = 2;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ack;
  logic [7:0] data;
  logic       rdy;
  logic       overrun;
  logic       err;

  int cyc = 0;
  int err_cnt = 0;
  int err_long = 0;
  int err_cyc = 0;
  int last_fall_cyc = 0;
  int total = 0;
  int bad = 0;
  int e0;
  int lat;
  logic err_prev = 1'b0;

  ps2_serial_rx #(
    .TIMEOUT_CYCLES(100),
    .FILTER_LEN    (8)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ack     (ack),
    .data    (data),
    .rdy     (rdy),
    .overrun (overrun),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // err pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
      if (err_prev) err_long = err_long + 1;
    end
    err_prev = err;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit ack_stop, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      repeat (8) tick();
      ps2_clk = 1'b0;
      repeat (3) tick();
      ps2_clk = 1'b1;
      repeat (HALF - 11) tick();
    end else begin
      repeat (HALF) tick();
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    if (ack_stop) begin
      repeat (ACK_DLY) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      repeat (HALF - ACK_DLY - 1) tick();
    end else begin
      repeat (HALF) tick();
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit ack_stop, input bit glitch);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, glitch && (i == 1 || i == 3));
    send_bit(par, 1'b0, 1'b0);
    send_bit(stp, ack_stop, 1'b0);
    ps2_data = 1'b1;
    repeat (HALF) tick();
  endtask

  task automatic do_ack;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ack = 1'b0;
    repeat (3) tick();
    check("rst_data", int'(data), 'h00);
    check("rst_rdy", int'(rdy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_err", int'(err), 0);
    clr = 1'b0;
    repeat (5) tick();

    // Bad parity: 0x1C has three ones, parity 1 makes total even.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    check("badpar_err", err_cnt - e0, 1);
    check("badpar_rdy", int'(rdy), 0);
    check("badpar_data", int'(data), 'h00);

    // Bad stop bit with correct parity.
    e0 = err_cnt;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check("badstop_err", err_cnt - e0, 1);
    check("badstop_rdy", int'(rdy), 0);

    // Good frame then ack.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("good_data", int'(data), 'h1C);
    check("good_rdy", int'(rdy), 1);
    check("good_overrun", int'(overrun), 0);
    check("good_err", err_cnt - e0, 0);
    do_ack();
    check("ack_rdy", int'(rdy), 0);
    check("ack_data", int'(data), 'h1C);

    // Overrun: second good frame while rdy held.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_data", int'(data), 'h1C);
    check("ovr_rdy", int'(rdy), 1);
    check("ovr_overrun", int'(overrun), 1);
    do_ack();
    check("ovr_ack_rdy", int'(rdy), 0);
    check("ovr_ack_overrun", int'(overrun), 0);

    // Ack coincident with completion of the second frame.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ackstop_data", int'(data), 'h32);
    check("ackstop_rdy", int'(rdy), 1);
    check("ackstop_overrun", int'(overrun), 0);
    do_ack();
    check("ackstop_clr_rdy", int'(rdy), 0);

    // Timeout: start plus three data bits then silence.
    e0 = err_cnt;
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    repeat (150) tick();
    check("to_err", err_cnt - e0, 1);
    lat = err_cyc - last_fall_cyc;
    check("to_latency_window", int'(lat >= 98 && lat <= 115), 1);
    check("to_rdy", int'(rdy), 0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    check("to_next_data", int'(data), 'h5A);
    check("to_next_rdy", int'(rdy), 1);

    // Reset mid-frame with rdy still set from 0x5A.
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 2 || i == 3, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_data", int'(data), 'h00);
    check("clr_rdy", int'(rdy), 0);
    check("clr_overrun", int'(overrun), 0);
    check("clr_err", int'(err), 0);
    repeat (5) tick();
    e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_next_data", int'(data), 'h29);
    check("clr_next_rdy", int'(rdy), 1);
    check("clr_next_err", err_cnt - e0, 0);
    do_ack();

    // Short low glitches on ps2_clk during a frame.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef PS2_CLK_FILTER_EN
    check("glitch_data", int'(data), 'h1C);
    check("glitch_rdy", int'(rdy), 1);
    check("glitch_err", err_cnt - e0, 0);
`else
    check("glitch_corrupts", int'((err_cnt != e0) || !(rdy && data == 8'h1C)), 1);
`endif
    repeat (150) tick();

    check("err_single_cycle", err_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_serial_rx.md
Name: ps2_serial_rx

Overview:
Serial-in, parallel-out receiver for the PS/2 keyboard port. It samples the device-driven ps2_clk/ps2_data pair in the system clock domain and assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop). It checks each frame and presents the byte with a held ready flag until the keyboard/PIA logic acknowledges it. It is the input-side counterpart of the video path's parallel-to-serial pixel shifter.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk falling edge mid-frame before the frame is abandoned (2 ms at 25 MHz)
FILTER_LEN, 8, consecutive identical samples required to change filtered ps2_clk (used only with the optional feature)

Ports:
clk  input  1  system clock
clr  input  1  synchronous active-high reset
ps2_clk  input  1  PS/2 clock from device, asynchronous, idle high
ps2_data  input  1  PS/2 data from device, asynchronous, idle high
ack  input  1  consumer has taken data; clears rdy
data  output  8  last good received byte
rdy  output  1  data valid, held until ack
overrun  output  1  sticky: good frame arrived while rdy=1
err  output  1  one-cycle pulse: parity, stop or timeout failure

Behaviour:
- One clock (clk). Reset clr is synchronous and active-high. On clr: data=0x00, rdy=0, overrun=0, err=0, state IDLE, bit count 0, timeout count 0, synchronizer/filter flops=1.
- ps2_clk and ps2_data each pass through 2-flop synchronizers. A falling edge is registered-previous=1 and current=0 on the (filtered) synced clock. Data is sampled from synced ps2_data in the same cycle the edge is detected.
- States: IDLE, DATA, PARITY, STOP.
- IDLE, on edge: data=0 goes to DATA with bit count 0. data=1 is ignored and stays IDLE with no err.
- DATA, on edge: shift register <= {ps2_data, sr[7:1]}. After the 8th bit go to PARITY.
- PARITY, on edge: capture the parity bit and go to STOP.
- STOP, on edge: frame is good if stop=1 and XOR(8 data bits, parity bit)=1. Always return to IDLE.
- Good frame, rdy=0: data<=sr and rdy<=1 on the cycle after the stop edge is detected. Without the filter, rdy rises at most 4 clk after the pin falling edge.
- Good frame, rdy=1 and no ack that cycle: data is not overwritten and overrun<=1.
- Good frame with ack in the same cycle: new byte loads, rdy stays 1, overrun is not set.
- Bad frame (parity or stop): err=1 for exactly one cycle. data and rdy are unchanged.
- ack while rdy=1: rdy<=0 and overrun<=0 next cycle. ack while rdy=0 has no effect.
- Timeout: the counter clears on every detected edge and in IDLE, and increments otherwise. In DATA, PARITY or STOP, reaching TIMEOUT_CYCLES-1 gives err pulse, return to IDLE and partial bits discarded.
- The counter saturates and does not wrap. Its width is clog2(TIMEOUT_CYCLES).
- clr mid-frame abandons the frame immediately. The next edge is treated as a possible start bit.
- No outputs toward the device; the receiver never drives ps2_clk/ps2_data.

Optional Feature:
PS2_CLK_FILTER_EN:
- Defined: synced ps2_clk feeds a FILTER_LEN-sample stability filter. Filtered clk changes only after FILTER_LEN consecutive equal samples. Pulses shorter than FILTER_LEN clk are rejected. Latency increases by FILTER_LEN cycles. ps2_data is delayed by FILTER_LEN so sampling alignment is unchanged. Filter state resets to 1.
- Undefined: synced ps2_clk is used directly and FILTER_LEN is unused.

Test Plan:
- Frame 0x1C, parity=0, stop=1 -> data=0x1C, rdy=1, err never asserted, overrun=0. Then ack -> rdy=0 next cycle, data stays 0x1C.
- Frame 0x1C with parity=1 -> single-cycle err, rdy stays 0, data stays 0x00. Frame 0x5A with parity=1 and stop=0 -> err pulse, rdy 0.
- Frame 0x1C, no ack, then frame 0x32 (parity 0) -> data=0x1C, rdy=1, overrun=1. Then ack -> rdy=0, overrun=0. Repeat with ack asserted in the cycle the 0x32 frame completes -> data=0x32, rdy=1, overrun=0.
- TIMEOUT_CYCLES=100: start plus 3 data bits, then idle for 150 clk -> err pulse at 100 clk after the last edge. Following full frame 0x5A (parity 1) -> data=0x5A, rdy=1.
- Assert clr for 1 cycle after 5 bits of frame 0x1C, then send full frame 0x29 (parity 0) -> outputs all 0 after reset, then data=0x29, rdy=1, no err.
- With PS2_CLK_FILTER_EN defined, FILTER_LEN=8: inject 3-cycle low glitches on ps2_clk during frame 0x1C -> data=0x1C, no err. Without the macro, the same stimulus -> err or wrong data.
